sw_autorepeat: RTL and testbench

Hold-to-repeat step generator between the per-switch debouncers and the up/down step counters. Converts the debounced up/down switch levels into single-cycle step pulses. A press gives one immediate pulse; holding the switch then gives repeat pulses after an initial delay, and, optionally, accelerates to a faster repeat rate. One instance serves one up/down switch pair, so the PWM channel's duty can be slewed by holding a switch rather than toggling it.

---
 rtl/sw_autorepeat_pkg.sv | 14 +
 rtl/sw_tick_timer.sv | 30 +++
 rtl/sw_autorepeat.sv | 131 +++++++++++++
 tb/tb_sw_autorepeat.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sw_autorepeat_pkg.sv
// sw_autorepeat_pkg: shared state/direction types and ms-to-cycle conversion for the autorepeat block.
package sw_autorepeat_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, FAST} ar_state_t;

    typedef enum logic {UP, DOWN} dir_t;

    function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
        int unsigned c;
        c = freq / 1000 * ms;
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/sw_tick_timer.sv
// sw_tick_timer: loadable down-counter; expire_o is high while the count sits at 1.
module sw_tick_timer #(
    parameter int W = 27
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expire_o
);

    logic [W-1:0] cnt;

    // expire is predicted one cycle ahead so it lines up with cnt == 1 while staying registered
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt      <= '0;
            expire_o <= 1'b0;
        end else if (load_i) begin
            cnt      <= value_i;
            expire_o <= value_i == W'(1);
        end else if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            expire_o <= cnt == W'(2);
        end else begin
            expire_o <= 1'b0;
        end
    end

endmodule

// File: rtl/sw_autorepeat.sv
// sw_autorepeat: hold-to-repeat up/down step pulse generator; accelerated FAST stage built when SW_AUTOREPEAT_FAST_EN is defined.
module sw_autorepeat
    import sw_autorepeat_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 100_000_000,
    parameter int unsigned DELAY_MS       = 500,
    parameter int unsigned REPEAT_MS      = 100,
    parameter int          FAST_AFTER     = 8,
    parameter int unsigned FAST_REPEAT_MS = 25,
    parameter int          WIDTH_TIMER    = 27
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic up_i,
    input  logic down_i,
    output logic up_pulse_o,
    output logic down_pulse_o,
    output logic held_o
);

    localparam int unsigned DELAY_CYC  = ms_to_cycles(CLOCK_FREQ, DELAY_MS);
    localparam int unsigned REPEAT_CYC = ms_to_cycles(CLOCK_FREQ, REPEAT_MS);
    localparam int unsigned FAST_CYC   = ms_to_cycles(CLOCK_FREQ, FAST_REPEAT_MS);
    localparam logic [WIDTH_TIMER-1:0] DELAY_V  = WIDTH_TIMER'(DELAY_CYC);
    localparam logic [WIDTH_TIMER-1:0] REPEAT_V = WIDTH_TIMER'(REPEAT_CYC);
    localparam logic [WIDTH_TIMER-1:0] FAST_V   = WIDTH_TIMER'(FAST_CYC);

    if (FAST_AFTER < 1 || (64'(DELAY_CYC) >> WIDTH_TIMER) != 64'd0) begin : g_param_err
        $error("sw_autorepeat: FAST_AFTER must be >= 1 and WIDTH_TIMER must hold DELAY_CYC");
    end

    ar_state_t state, state_n;
    dir_t dir, dir_n;
    logic pulse, load, expire, dir_in, opp_in, abort;
    logic [WIDTH_TIMER-1:0] load_val;

`ifdef SW_AUTOREPEAT_FAST_EN
    localparam int RW = $clog2(FAST_AFTER + 1);
    logic [RW-1:0] rep_cnt, rep_n;

    always_ff @(posedge clk_i) begin
        if (reset_i) rep_cnt <= '0;
        else rep_cnt <= rep_n;
    end
`endif

    sw_tick_timer #(.W(WIDTH_TIMER)) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (load),
        .value_i  (load_val),
        .expire_o (expire)
    );

    assign dir_in = (dir == UP) ? up_i : down_i;
    assign opp_in = (dir == UP) ? down_i : up_i;
    assign abort  = !enable_i || !dir_in || opp_in;

    // abort always wins over a same-cycle expiry, so a release never yields a late pulse
    always_comb begin
        state_n  = state;
        dir_n    = dir;
        pulse    = 1'b0;
        load     = 1'b0;
        load_val = REPEAT_V;
`ifdef SW_AUTOREPEAT_FAST_EN
        rep_n    = rep_cnt;
`endif
        case (state)
            IDLE: if (enable_i && (up_i ^ down_i)) begin
                state_n  = DELAY;
                dir_n    = up_i ? UP : DOWN;
                pulse    = 1'b1;
                load     = 1'b1;
                load_val = DELAY_V;
            end
            DELAY: if (abort) state_n = IDLE;
            else if (expire) begin
                state_n = REPEAT;
                pulse   = 1'b1;
                load    = 1'b1;
`ifdef SW_AUTOREPEAT_FAST_EN
                rep_n   = RW'(1);
                if (FAST_AFTER <= 1) begin
                    state_n  = FAST;
                    load_val = FAST_V;
                end
`endif
            end
            REPEAT: if (abort) state_n = IDLE;
            else if (expire) begin
                pulse = 1'b1;
                load  = 1'b1;
`ifdef SW_AUTOREPEAT_FAST_EN
                if (int'(rep_cnt) + 1 >= FAST_AFTER) begin
                    state_n  = FAST;
                    load_val = FAST_V;
                    rep_n    = RW'(FAST_AFTER);
                end else begin
                    rep_n = rep_cnt + 1'b1;
                end
`endif
            end
            FAST: if (abort) state_n = IDLE;
            else if (expire) begin
                pulse    = 1'b1;
                load     = 1'b1;
                load_val = FAST_V;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            dir          <= UP;
            up_pulse_o   <= 1'b0;
            down_pulse_o <= 1'b0;
            held_o       <= 1'b0;
        end else begin
            state        <= state_n;
            dir          <= dir_n;
            up_pulse_o   <= pulse && dir_n == UP;
            down_pulse_o <= pulse && dir_n == DOWN;
            held_o       <= state_n != IDLE;
        end
    end

endmodule

// File: tb/tb_sw_autorepeat.sv
// tb_sw_autorepeat: table-driven and hand-written cycle checks of sw_autorepeat at 1 kHz scaled timing.
module tb_sw_autorepeat;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic up = 1'b0;
    logic down = 1'b0;
    logic up_p, dn_p, held;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sw_autorepeat #(
        .CLOCK_FREQ     (1000),
        .DELAY_MS       (5),
        .REPEAT_MS      (2),
        .FAST_AFTER     (3),
        .FAST_REPEAT_MS (1),
        .WIDTH_TIMER    (8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .up_i         (up),
        .down_i       (down),
        .up_pulse_o   (up_p),
        .down_pulse_o (dn_p),
        .held_o       (held)
    );

    typedef struct {
        int up_lo, up_hi, dn_lo, dn_hi, rst_c, en_c;
        logic [31:0] eu, ed, eh;
    } vec_t;

    vec_t v[6];

    function automatic logic [31:0] p(input int n);
        return 32'd1 << n;
    endfunction

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string nm, input int c, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b want %b", nm, c, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input int c, input logic eu, input logic ed, input logic eh);
        chk({nm, " up_pulse"}, c, up_p, eu);
        chk({nm, " down_pulse"}, c, dn_p, ed);
        chk({nm, " held"}, c, held, eh);
        chk({nm, " exclusive"}, c, up_p & dn_p, 1'b0);
    endtask

    task automatic run(input vec_t t, input int id);
        for (int c = 0; c < 32; c++) begin
            @(posedge clk);
            #1;
            reset  = (c < 2) || (c == t.rst_c);
            enable = (c != t.en_c);
            up     = (c >= t.up_lo) && (c <= t.up_hi);
            down   = (c >= t.dn_lo) && (c <= t.dn_hi);
            @(negedge clk);
            if (c > 0) check_outs($sformatf("vec%0d", id), c, t.eu[c], t.ed[c], t.eh[c]);
        end
    endtask

    initial begin
        // steady hold of up
        v[0] = '{10, 25, 0, -1, -1, -1, 32'd0, 32'd0, rng(11, 26)};
`ifdef SW_AUTOREPEAT_FAST_EN
        v[0].eu = p(11) | p(16) | p(18) | p(20) | rng(21, 26);
`else
        v[0].eu = p(11) | p(16) | p(18) | p(20) | p(22) | p(24) | p(26);
`endif
        // short down tap
        v[1] = '{0, -1, 10, 13, -1, -1, 32'd0, p(11), rng(11, 14)};
        // both high: never a press
        v[2] = '{10, 20, 10, 20, -1, -1, 32'd0, 32'd0, 32'd0};
        // reversal up -> down
        v[3] = '{10, 17, 16, 31, -1, -1, p(11) | p(16), 32'd0, rng(11, 16) | rng(19, 31)};
        // reset mid-hold
        v[4] = '{10, 31, 0, -1, 17, -1, 32'd0, 32'd0, rng(11, 17) | rng(19, 31)};
`ifdef SW_AUTOREPEAT_FAST_EN
        v[3].ed = p(19) | p(24) | p(26) | p(28) | rng(29, 31);
        v[4].eu = p(11) | p(16) | p(19) | p(24) | p(26) | p(28) | rng(29, 31);
`else
        v[3].ed = p(19) | p(24) | p(26) | p(28) | p(30);
        v[4].eu = p(11) | p(16) | p(19) | p(24) | p(26) | p(28) | p(30);
`endif
        // one-cycle enable drop during delay
        v[5] = '{10, 16, 0, -1, -1, 13, p(11) | p(15), 32'd0, rng(11, 13) | rng(15, 17)};

        for (int s = 0; s < 6; s++) run(v[s], s);

        // down pressed while up still held: no down press until up releases
        for (int c = 0; c < 21; c++) begin
            @(posedge clk);
            #1;
            reset  = c < 2;
            enable = 1'b1;
            up     = (c >= 2) && (c <= 14);
            down   = c >= 9;
            @(negedge clk);
            if (c > 0) check_outs("slide", c, (c == 3) || (c == 8), c == 16, ((c >= 3) && (c <= 9)) || (c >= 16));
        end

        // press held while disabled is taken only once enable rises
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            reset  = c < 2;
            enable = c >= 6;
            up     = c >= 2;
            down   = 1'b0;
            @(negedge clk);
            if (c > 0) check_outs("enable_rise", c, (c == 7) || (c == 12), 1'b0, c >= 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
